// File: rtl/reg_file_3p.sv
// reg_file_3p: MIPS 3-port GPR file (2 comb reads, 1 sync write, $0 reads 0) with a bulk-clear engine.
// Latency: reads 0 cycles; a write is visible one edge later; a clear of $1..$31 takes 31 edges.
// Backpressure: none; a write offered while busy is dropped and flagged on wr_drop for one cycle.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   A1/RD1, A2/RD2  read address / data, ports 1 (rs) and 2 (rt); address 0 always reads 0
//   A3, WD3, WE3    write address (from RegDst mux), write data, write enable (RegWrite)
//   clr_req         start a bulk clear of registers 1..31 (ignored while one is running)
//   busy            registered, high while the clear sequence runs
//   wr_drop         registered, one-cycle pulse after a write was discarded because of busy
module reg_file_3p #(
    parameter int DATA_W = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        A1,
    input  logic [4:0]        A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic [4:0]        A3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              WE3,
    input  logic              clr_req,
    output logic              busy,
    output logic              wr_drop
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_CLEAR = 1'b1;

    logic                         state;
    logic [4:0]                   cnt;
    logic [31:1][DATA_W-1:0]      regs_q;   // no storage behind address 0

    logic wr_req;
    logic wr_ok;
    logic byp1;
    logic byp2;

    assign wr_req = WE3 && (A3 != 5'd0);
    assign wr_ok  = wr_req && (state == ST_IDLE);

    // Forwarding only applies to a write that will actually land this edge.
    assign byp1 = BYPASS && wr_ok && (A3 == A1);
    assign byp2 = BYPASS && wr_ok && (A3 == A2);

    always_comb begin
        RD1 = '0;
        if (A1 != 5'd0) begin
            if (byp1) begin
                RD1 = WD3;
            end else begin
                RD1 = regs_q[A1];
            end
        end
    end

    always_comb begin
        RD2 = '0;
        if (A2 != 5'd0) begin
            if (byp2) begin
                RD2 = WD3;
            end else begin
                RD2 = regs_q[A2];
            end
        end
    end

    // Register storage: the clear engine and the write port are mutually
    // exclusive by state, so no priority question arises between them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else if (state == ST_CLEAR) begin
            regs_q[cnt] <= '0;
        end else if (wr_ok) begin
            regs_q[A3] <= WD3;
        end
    end

    // Clear sequencer: cnt walks 1..31, one register per edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= 5'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state <= ST_CLEAR;
                        cnt   <= 5'd1;
                    end
                end
                default: begin
                    if (cnt == 5'd31) begin
                        state <= ST_IDLE;
                        cnt   <= 5'd0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= wr_req && (state == ST_CLEAR);
        end
    end

    // State is itself a flop, so busy has no combinational input path.
    assign busy = (state == ST_CLEAR);

endmodule

// File: tb/tb_reg_file_3p.sv
module tb_reg_file_3p;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [4:0]   A1, A2, A3;
    logic [W-1:0] WD3;
    logic         WE3, clr_req;

    logic [W-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic         busy_b, drop_b, busy_n, drop_n;

    always #5 clk = ~clk;

    reg_file_3p #(.DATA_W(W), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst_n(rst_n), .A1(A1), .A2(A2), .RD1(rd1_b), .RD2(rd2_b),
        .A3(A3), .WD3(WD3), .WE3(WE3), .clr_req(clr_req), .busy(busy_b), .wr_drop(drop_b)
    );

    reg_file_3p #(.DATA_W(W), .BYPASS(1'b0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .A1(A1), .A2(A2), .RD1(rd1_n), .RD2(rd2_n),
        .A3(A3), .WD3(WD3), .WE3(WE3), .clr_req(clr_req), .busy(busy_n), .wr_drop(drop_n)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // A clear started at edge E zeroes register k at edge E+k and is over after E+31.
    logic [W-1:0] m_reg [32];
    bit           m_active;
    bit           m_busy;
    bit           m_drop;
    int           m_edge;
    int           m_start;

    always @(posedge clk or negedge rst_n) begin
        int k;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_reg[i] = '0;
            m_active = 0;
            m_busy   = 0;
            m_drop   = 0;
            m_edge   = 0;
            m_start  = 0;
        end else begin
            m_edge++;
            if (m_active) begin
                k = m_edge - m_start;
                m_reg[k] = '0;
                m_drop = WE3 && (A3 != 0);
                if (k == 31) m_active = 0;
            end else begin
                m_drop = 0;
                if (WE3 && (A3 != 0)) m_reg[A3] = WD3;
                if (clr_req) begin
                    m_active = 1;
                    m_start  = m_edge;
                end
            end
            m_busy = m_active;
        end
    end

    function automatic logic [W-1:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && WE3 && !m_busy && (A3 == a)) return WD3;
        return m_reg[a];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd1_byp",   rd1_b,       exp_rd(A1, 1'b1));
            chk("rd2_byp",   rd2_b,       exp_rd(A2, 1'b1));
            chk("rd1_nobyp", rd1_n,       exp_rd(A1, 1'b0));
            chk("rd2_nobyp", rd2_n,       exp_rd(A2, 1'b0));
            chk("busy_byp",  W'(busy_b),  W'(m_busy));
            chk("busy_nobyp",W'(busy_n),  W'(m_busy));
            chk("drop_byp",  W'(drop_b),  W'(m_drop));
            chk("drop_nobyp",W'(drop_n),  W'(m_drop));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int busy_cnt;

    initial begin
        A1 = 0; A2 = 0; A3 = 0; WD3 = '0; WE3 = 0; clr_req = 0;
        #8 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("reset_busy", W'(busy_b), '0);
        chk("reset_drop", W'(drop_b), '0);

        // basic write then read
        step(); A3 = 5; WD3 = 32'hDEADBEEF; WE3 = 1;
        step(); WE3 = 0; A1 = 5; A2 = 0;
        #1;
        chk("wr5_rd1_byp",   rd1_b, 32'hDEADBEEF);
        chk("wr5_rd1_nobyp", rd1_n, 32'hDEADBEEF);
        chk("rd_zero",       rd2_b, 32'h0);

        // same-cycle forwarding
        step(); WE3 = 1; A3 = 7; WD3 = 32'h12345678; A1 = 7; A2 = 5;
        #1;
        chk("bypass_on",  rd1_b, 32'h12345678);
        chk("bypass_off", rd1_n, 32'h0);
        chk("bypass_rd2", rd2_b, 32'hDEADBEEF);

        // write to $0 is ignored silently
        step(); A3 = 0; WD3 = 32'hFFFFFFFF; WE3 = 1; A1 = 0; A2 = 7;
        #1;
        chk("r0_bypass", rd1_b, 32'h0);
        chk("r7_after",  rd2_n, 32'h12345678);
        step(); WE3 = 0; A1 = 0;
        #1;
        chk("r0_stays0", rd1_b, 32'h0);
        chk("r0_nodrop", W'(drop_b), '0);

        // fill 1..31 with their index
        for (int i = 1; i < 32; i++) begin
            step(); WE3 = 1; A3 = 5'(i); WD3 = W'(i);
        end
        // write accepted in the clr_req cycle
        step(); WE3 = 1; A3 = 3; WD3 = 32'h55; clr_req = 1;

        busy_cnt = 0;
        for (int j = 0; j < 40; j++) begin
            step();
            WE3 = 0; clr_req = 0; A1 = 0; A2 = 0;
            case (j)
                2, 3: A1 = 3;
                5:    begin WE3 = 1; A3 = 20; WD3 = 32'hAA; end
                8:    clr_req = 1;
                10:   begin A1 = 10; A2 = 11; end
                default: ;
            endcase
            #1;
            if (busy_b) busy_cnt++;
            if (j == 0)  chk("clr_busy_first", W'(busy_b), 32'h1);
            if (j == 2)  chk("r3_before_clr", rd1_b, 32'h55);
            if (j == 3)  chk("r3_cleared",    rd1_b, 32'h0);
            if (j == 6)  chk("drop_pulse",    W'(drop_b), 32'h1);
            if (j == 7)  chk("drop_one_cyc",  W'(drop_b), 32'h0);
            if (j == 10) chk("mid_r10",       rd1_b, 32'h0);
            if (j == 10) chk("mid_r11",       rd2_b, 32'd11);
            if (j == 30) chk("busy_last",     W'(busy_b), 32'h1);
            if (j == 31) chk("busy_fell",     W'(busy_b), 32'h0);
        end
        chk("busy_cycles", W'(busy_cnt), 32'd31);

        for (int i = 1; i < 32; i++) begin
            step(); A1 = 5'(i); A2 = 5'(32 - i);
            #1;
            chk("post_clr_zero", rd1_n, 32'h0);
        end

        // asynchronous reset in the middle of a clear
        step(); WE3 = 1; A3 = 9; WD3 = 32'h99; A1 = 9;
        step(); WE3 = 0; clr_req = 1;
        step(); clr_req = 0;
        step(); WE3 = 1; A3 = 25; WD3 = 32'h1;
        step(); WE3 = 0;
        chk("pre_rst_drop", W'(drop_b), 32'h1);
        chk("pre_rst_r9",   rd1_b, 32'h99);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", W'(busy_b), 32'h0);
        chk("arst_drop", W'(drop_b), 32'h0);
        chk("arst_r9",   rd1_b, 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        WE3 = 1; A3 = 1; WD3 = 32'h1; A1 = 1;
        step(); WE3 = 0;
        #1;
        chk("post_rst_wr", rd1_n, 32'h1);

        // randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            step();
            A1      = 5'($urandom);
            A2      = 5'($urandom);
            A3      = 5'($urandom);
            WD3     = $urandom;
            WE3     = 1'($urandom_range(0, 1));
            clr_req = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        step();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
